alu_operand_regs: RTL
=====================

# alu_operand_regs

Operand and flag register stage wrapped around the combinational ALU. Holds the A (accumulator) and B operand registers and drives them into the ALU. Captures the ALU result's carry and zero flags into a flags register for conditional jumps, and returns the ALU result or the A register onto the shared 8-bit bus under microcode control.

## Interface
Parameters:
- WIDTH, 8, datapath width. Bus, A, B and ALU result all share this width.

Ports:
- clk  input  1  system clock. Every register updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- bus_in  input  WIDTH  current value of the shared bus.
- ai  input  1  load A from bus_in.
- bi  input  1  load B from bus_in.
- ao  input  1  drive A onto the bus.
- eo  input  1  drive the ALU result onto the bus.
- su  input  1  subtract select, forwarded to the ALU.
- fi  input  1  load the flags register.
- alu_out  input  WIDTH  result returned from the ALU.
- alu_a  output  WIDTH  equals the A register.
- alu_b  output  WIDTH  equals the B register.
- alu_sub  output  1  equals su (combinational pass-through).
- bus_out  output  WIDTH  value this block drives onto the bus.
- bus_oe  output  1  high when ao or eo is asserted.
- carry_flag  output  1  registered carry.
- zero_flag  output  1  registered zero.
- bus_conflict  output  1  sticky error flag; set when ao and eo are asserted in the same cycle.

## Operation
- A register:
  - On clk with ai=1: A <= bus_in.
  - Otherwise A holds.
- B register:
  - On clk with bi=1: B <= bus_in.
  - Otherwise B holds.
- Bus drive (combinational):
  - eo=1: bus_out = alu_out. eo has priority over ao.
  - eo=0, ao=1: bus_out = A.
  - Neither asserted: bus_out = 0 and bus_oe = 0.
- Carry (combinational, from the registers, independent of alu_out):
  - The carry is bit WIDTH of the (WIDTH+1)-bit sum {0,A} + {0,B'} + su.
  - B' = B with every bit inverted when su=1, otherwise B unchanged.
  - For subtraction, carry=1 means no borrow (A >= B, unsigned).
- Zero (combinational): zero = (alu_out == 0).
- Flags register:
  - On clk with fi=1: carry_flag <= carry, zero_flag <= zero.
  - Otherwise both flags hold.
  - Flags load only under fi; ai, bi, eo do not touch them.
- Conflict:
  - On clk with ao=1 and eo=1: bus_conflict <= 1.
  - bus_conflict stays set until rst.
- Simultaneous loads:
  - ai and bi may both be 1; both registers load the same bus_in.
  - ai, eo and fi together (the ADD/SUB microstep) behave as follows:
    - A loads bus_in, which the top-level bus mux supplies from bus_out, i.e. the pre-edge alu_out.
    - The flags capture values computed from the pre-edge A and B.
    - There is no combinational loop through the registers.
- Width rule: all arithmetic wraps modulo 2^WIDTH. Carry out is the only overflow indication; there is no signed overflow flag.

## Timing
- Reset: on clk with rst=1, A, B, carry_flag, zero_flag and bus_conflict all go to 0.
- rst overrides every load in the same cycle, including mid-microinstruction.
- After reset, alu_a = alu_b = 0. bus_out, bus_oe and alu_sub follow the control inputs, since they are combinational.
- Load latency:
  - A register written at edge N is visible on alu_a and bus_out (ao) right after edge N.
  - A flag computed from it is captured by fi at edge N+1 at the earliest.
- Combinational paths are: control inputs to bus_out/bus_oe/alu_sub; A/B to alu_a/alu_b; alu_out to bus_out. No path exists from bus_in to any output.
- One microstep per clock. There is no handshake or stall; every control bit acts on the edge it is sampled at.

## Test plan
- Reset: preload A=0x55, B=0xAA and flags=1, assert rst for one clk -> A=B=0, carry_flag=zero_flag=0, bus_conflict=0. Hold rst with ai=1, bus_in=0xFF -> A stays 0.
- Add with carry: load A=0xF0, B=0x20, su=0. Model alu_out=0x10. Assert eo, ai, fi for one clk -> A=0x10, carry_flag=1, zero_flag=0. bus_out was 0x10 with bus_oe=1 during that cycle.
- Subtract to zero: A=0x07, B=0x07, su=1, model alu_out=0x00, fi=1 -> carry_flag=1, zero_flag=1. Repeat with A=0x03, B=0x05 (alu_out=0xFE) -> carry_flag=0, zero_flag=0.
- Flag hold: after the subtract-to-zero step, change A to 0x01 with fi=0 for 3 clks -> zero_flag stays 1 and carry_flag stays 1.
- Bus priority and conflict: A=0x3C, alu_out=0xC3, ao=eo=1 -> bus_out=0xC3 and bus_oe=1. After the edge, bus_conflict=1, and it stays 1 through later idle cycles until rst.
- Idle and dual load: ao=eo=0 -> bus_out=0 and bus_oe=0. Then ai=bi=1 with bus_in=0x99 -> A=B=0x99 after one clk.

Source files
------------

// File: rtl/alu_operand_regs.sv
// rtl/alu_operand_regs.sv - A/B operand registers, carry/zero flags and bus return path around the ALU
// Carry is rebuilt from the registered operands so the flags never depend on the external ALU's timing.
module alu_operand_regs #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             ai,
    input  logic             bi,
    input  logic             ao,
    input  logic             eo,
    input  logic             su,
    input  logic             fi,
    input  logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_sub,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic             bus_conflict
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             conflict_q, conflict_d;

    logic [WIDTH-1:0] b_eff;
    logic             carry_now;
    logic             zero_now;

    // Ripple only the carry chain of A + B' + su; the sum bits come from the external ALU.
    always_comb begin
        b_eff     = su ? ~b_q : b_q;
        carry_now = su;
        for (int i = 0; i < WIDTH; i++) begin
            carry_now = (a_q[i] & b_eff[i]) | (carry_now & (a_q[i] ^ b_eff[i]));
        end
        zero_now = (alu_out == '0);
    end

    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        conflict_d = conflict_q;
        if (ai) begin
            a_d = bus_in;
        end
        if (bi) begin
            b_d = bus_in;
        end
        if (fi) begin
            carry_d = carry_now;
            zero_d  = zero_now;
        end
        if (ao && eo) begin
            conflict_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            conflict_q <= conflict_d;
        end
    end

    // eo wins over ao so a microcode slip still yields a defined bus value.
    always_comb begin
        bus_out = '0;
        if (eo) begin
            bus_out = alu_out;
        end else if (ao) begin
            bus_out = a_q;
        end
    end

    assign bus_oe       = ao | eo;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_sub      = su;
    assign carry_flag   = carry_q;
    assign zero_flag    = zero_q;
    assign bus_conflict = conflict_q;

endmodule
